// File: rtl/spi_master_bridge_pkg.sv
// Shared definitions for the SPI master bridge: word width, timing defaults
// and the frame sequencer state encoding.
package spi_master_bridge_pkg;

    localparam int AUDIO_WORD_W    = 16;
    localparam int DEFAULT_CLK_DIV = 4;
    localparam int DEFAULT_CS_GAP  = 4;
    localparam int HALF_CNT_W      = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SETUP = 3'd3,
        SHIFT = 3'd4,
        HOLD  = 3'd5,
        GAP   = 3'd6
    } state_t;

endpackage

// File: rtl/spi_master_bridge_if.sv
// FIFO handshake and SPI pin bundle for the SPI master bridge.
// master = bridge side, slave = FIFO/peripheral side.
interface spi_master_bridge_if
    import spi_master_bridge_pkg::*;
#(
    parameter int WORD_W = AUDIO_WORD_W
);
    logic [WORD_W-1:0] tx_dout;
    logic              tx_empty;
    logic              tx_rd_en;
    logic [WORD_W-1:0] rx_din;
    logic              rx_wr_en;
    logic              rx_full;
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;

    modport master (
        input  tx_dout, tx_empty, rx_full, miso,
        output tx_rd_en, rx_din, rx_wr_en, sclk, cs_n, mosi
    );

    modport slave (
        output tx_dout, tx_empty, rx_full, miso,
        input  tx_rd_en, rx_din, rx_wr_en, sclk, cs_n, mosi
    );

endinterface

// File: rtl/spi_master_bridge_clk_gen.sv
// Half-period tick counter for sclk. Restarts on start, idles at zero when
// not running, and splits each terminal count into a rise or fall strobe
// depending on the current sclk level.
module spi_clk_gen
    import spi_master_bridge_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    input  logic sclk_level,
    output logic tick_rise,
    output logic tick_fall
);
    localparam logic [HALF_CNT_W-1:0] HALF_LAST = HALF_CNT_W'(CLK_DIV - 1);

    logic [HALF_CNT_W-1:0] half_cnt_reg;
    logic                  tick;

    assign tick      = run && (half_cnt_reg == HALF_LAST);
    assign tick_rise = tick && !sclk_level;
    assign tick_fall = tick && sclk_level;

    // Count clk_sys cycles within the current sclk half-period.
    always_ff @(posedge clk_sys) begin
        if (!rst_n || start || !run) begin
            half_cnt_reg <= '0;
        end else if (tick) begin
            half_cnt_reg <= '0;
        end else begin
            half_cnt_reg <= half_cnt_reg + HALF_CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_bridge.sv
// SPI master (CPOL=0, CPHA=1): pops one TX word per cs_n frame, shifts it
// out MSB-first while capturing miso, and pushes the captured word to RX.
module spi_master_bridge
    import spi_master_bridge_pkg::*;
#(
    parameter int WORD_W  = AUDIO_WORD_W,
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int CS_GAP  = DEFAULT_CS_GAP
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic enable,
    input  logic ovf_clr,
    output logic busy,
    output logic overflow,
    spi_master_bridge_if.master bus
);
    localparam int BIT_CNT_W = $clog2(WORD_W) + 1;
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST = BIT_CNT_W'(WORD_W);
    localparam logic [HALF_CNT_W-1:0] GAP_LAST = HALF_CNT_W'(CS_GAP - 1);

    state_t                state_reg, state_next;
    logic [WORD_W-1:0]     shift_reg, shift_next;
    logic [WORD_W-1:0]     rx_shift_reg, rx_shift_next;
    logic [WORD_W-1:0]     rx_din_reg, rx_din_next;
    logic [BIT_CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [HALF_CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic                  sclk_reg, sclk_next;
    logic                  cs_n_reg, cs_n_next;
    logic                  mosi_reg, mosi_next;
    logic                  tx_rd_en_reg, tx_rd_en_next;
    logic                  rx_wr_en_reg, rx_wr_en_next;
    logic                  rx_pending_reg, rx_pending_next;
    logic                  overflow_reg, overflow_next;
    logic                  ovf_set;
    logic                  tick_rise, tick_fall;
    logic                  clk_run;

    // The half-period counter runs only while cs_n is low.
    assign clk_run = (state_reg == SETUP) || (state_reg == SHIFT) || (state_reg == HOLD);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .start      (state_reg == LOAD),
        .run        (clk_run),
        .sclk_level (sclk_reg),
        .tick_rise  (tick_rise),
        .tick_fall  (tick_fall)
    );

    // Frame sequencer: next state and next values of all registered outputs.
    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        rx_shift_next   = rx_shift_reg;
        rx_din_next     = rx_din_reg;
        bit_cnt_next    = bit_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        sclk_next       = sclk_reg;
        cs_n_next       = cs_n_reg;
        mosi_next       = mosi_reg;
        rx_pending_next = rx_pending_reg;
        tx_rd_en_next   = 1'b0;
        rx_wr_en_next   = 1'b0;
        ovf_set         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (enable && !bus.tx_empty) begin
                    tx_rd_en_next = 1'b1;
                    state_next    = FETCH;
                end
            end
            FETCH: begin
                // FIFO data appears one cycle after the pop.
                state_next = LOAD;
            end
            LOAD: begin
                shift_next   = bus.tx_dout;
                cs_n_next    = 1'b0;
                bit_cnt_next = '0;
                state_next   = SETUP;
            end
            SETUP: begin
                if (tick_rise) begin
                    sclk_next  = 1'b1;
                    mosi_next  = shift_reg[WORD_W-1];
                    shift_next = {shift_reg[WORD_W-2:0], 1'b0};
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (tick_fall) begin
                    // miso comes straight from the slave, which launched it on
                    // the preceding sclk rise, so no synchroniser is needed.
                    sclk_next     = 1'b0;
                    rx_shift_next = {rx_shift_reg[WORD_W-2:0], bus.miso};
                    bit_cnt_next  = bit_cnt_reg + BIT_CNT_W'(1);
                end else if (tick_rise) begin
                    if (bit_cnt_reg == BIT_LAST) begin
                        rx_pending_next = 1'b1;
                        state_next      = HOLD;
                    end else begin
                        sclk_next  = 1'b1;
                        mosi_next  = shift_reg[WORD_W-1];
                        shift_next = {shift_reg[WORD_W-2:0], 1'b0};
                    end
                end
            end
            HOLD: begin
                if (rx_pending_reg) begin
                    rx_pending_next = 1'b0;
                    if (!bus.rx_full) begin
                        rx_din_next   = rx_shift_reg;
                        rx_wr_en_next = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
                if (tick_rise) begin
                    cs_n_next    = 1'b1;
                    mosi_next    = 1'b0;
                    gap_cnt_next = '0;
                    state_next   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    gap_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + HALF_CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A drop in the same cycle as a clear must still be reported.
        if (ovf_set) begin
            overflow_next = 1'b1;
        end else if (ovf_clr) begin
            overflow_next = 1'b0;
        end else begin
            overflow_next = overflow_reg;
        end
    end

    // State and output registers; reset abandons any in-flight frame.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            rx_shift_reg   <= '0;
            rx_din_reg     <= '0;
            bit_cnt_reg    <= '0;
            gap_cnt_reg    <= '0;
            sclk_reg       <= 1'b0;
            cs_n_reg       <= 1'b1;
            mosi_reg       <= 1'b0;
            tx_rd_en_reg   <= 1'b0;
            rx_wr_en_reg   <= 1'b0;
            rx_pending_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            rx_shift_reg   <= rx_shift_next;
            rx_din_reg     <= rx_din_next;
            bit_cnt_reg    <= bit_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            sclk_reg       <= sclk_next;
            cs_n_reg       <= cs_n_next;
            mosi_reg       <= mosi_next;
            tx_rd_en_reg   <= tx_rd_en_next;
            rx_wr_en_reg   <= rx_wr_en_next;
            rx_pending_reg <= rx_pending_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign bus.sclk     = sclk_reg;
    assign bus.cs_n     = cs_n_reg;
    assign bus.mosi     = mosi_reg;
    assign bus.tx_rd_en = tx_rd_en_reg;
    assign bus.rx_wr_en = rx_wr_en_reg;
    assign bus.rx_din   = rx_din_reg;
    assign busy         = (state_reg != IDLE);
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_spi_master_bridge.sv
// Bench for spi_master_bridge: FIFO and SPI slave models, a frame monitor
// and directed plus randomized frames checked against word-level expectations.
`timescale 1ns/1ps
module tb_spi_master_bridge;
    import spi_master_bridge_pkg::*;

    localparam int W         = 16;
    localparam int DIV       = 2;
    localparam int GAPC      = 4;
    localparam int FRAME_LOW = (2 * W + 2) * DIV;
    localparam int MIN_SEP   = GAPC + 3;

    typedef struct {
        int           low_len;
        int           rises;
        logic [W-1:0] mosi_word;
        int           lat;
        int           sep;
    } frame_t;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    logic enable  = 1'b0;
    logic ovf_clr = 1'b0;
    logic busy;
    logic overflow;

    spi_master_bridge_if #(.WORD_W(W)) bus ();

    spi_master_bridge #(
        .WORD_W  (W),
        .CLK_DIV (DIV),
        .CS_GAP  (GAPC)
    ) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .enable   (enable),
        .ovf_clr  (ovf_clr),
        .busy     (busy),
        .overflow (overflow),
        .bus      (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] tx_q[$];
    logic [W-1:0] slave_q[$];
    logic [W-1:0] rx_got[$];
    frame_t       frames[$];

    int           miso_mode = 0;  // 0 loopback, 1 tied high, 2 scripted slave words
    int           cyc = 0, rd_cnt = 0, rd_cyc = 0, act_cnt = 0;
    int           cur_low = 0, cur_rises = 0, cur_lat = 0, cur_sep = 0, high_len = 0;
    logic [W-1:0] cur_mosi = '0;
    logic [W-1:0] slave_sh = '0;
    logic         prev_sclk = 1'b0;
    logic         prev_cs = 1'b1;
    logic         pop_now;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [W-1:0] w);
        tx_q.push_back(w);
        bus.tx_empty = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames.size() < n && k < budget) begin
            @(negedge clk_sys);
            k++;
        end
        check("frame_timeout", frames.size() >= n, 1);
    endtask

    task automatic wait_bit(input int r, input int budget);
        int k = 0;
        while (!(cur_rises == r && bus.cs_n === 1'b0) && k < budget) begin
            @(negedge clk_sys);
            k++;
        end
        check("bit_timeout", k < budget, 1);
    endtask

    task automatic check_frame(input string tag, input logic [W-1:0] exp_mosi, output int sep);
        frame_t f;
        sep = 0;
        check({tag, "_present"}, frames.size() > 0, 1);
        if (frames.size() > 0) begin
            f = frames.pop_front();
            sep = f.sep;
            check({tag, "_cs_low"}, f.low_len, FRAME_LOW);
            check({tag, "_rises"}, f.rises, W);
            check({tag, "_mosi"}, f.mosi_word, exp_mosi);
            check({tag, "_lat"}, f.lat, 2);
            $display("frame %s: mosi=%04h cs_low=%0d rises=%0d lat=%0d sep=%0d",
                     tag, f.mosi_word, f.low_len, f.rises, f.lat, f.sep);
        end
    endtask

    task automatic check_rx(input string tag, input logic [W-1:0] exp);
        logic [W-1:0] got;
        check({tag, "_rx_present"}, rx_got.size() > 0, 1);
        if (rx_got.size() > 0) begin
            got = rx_got.pop_front();
            check({tag, "_rx"}, got, exp);
            $display("rx %s: word=%04h want=%04h", tag, got, exp);
        end
    endtask

    // TX FIFO model: data is presented the cycle after a pop.
    always @(posedge clk_sys) begin
        pop_now = bus.tx_rd_en;
        #1;
        if (pop_now === 1'b1) begin
            if (tx_q.size() > 0) bus.tx_dout = tx_q.pop_front();
            bus.tx_empty = (tx_q.size() == 0);
        end
    end

    // Frame monitor and SPI slave model, evaluated between clock edges.
    always @(negedge clk_sys) begin
        cyc++;
        if (bus.tx_rd_en === 1'b1) begin
            rd_cnt++;
            rd_cyc = cyc;
        end
        if (bus.rx_wr_en === 1'b1) rx_got.push_back(bus.rx_din);
        if (bus.cs_n === 1'b0 || bus.sclk === 1'b1 || busy === 1'b1) act_cnt++;
        if (prev_cs === 1'b1 && bus.cs_n === 1'b0) begin
            cur_low   = 0;
            cur_rises = 0;
            cur_mosi  = '0;
            cur_sep   = high_len;
            high_len  = 0;
            cur_lat   = cyc - rd_cyc;
            slave_sh  = '0;
            if (slave_q.size() > 0) slave_sh = slave_q.pop_front();
        end
        if (bus.cs_n === 1'b0) cur_low++;
        else high_len++;
        if (prev_sclk === 1'b0 && bus.sclk === 1'b1) begin
            cur_rises++;
            cur_mosi = {cur_mosi[W-2:0], bus.mosi};
            if (miso_mode == 2) begin
                bus.miso = slave_sh[W-1];
                slave_sh = {slave_sh[W-2:0], 1'b0};
            end
        end
        if (prev_cs === 1'b0 && bus.cs_n === 1'b1)
            frames.push_back('{cur_low, cur_rises, cur_mosi, cur_lat, cur_sep});
        if (miso_mode == 0) bus.miso = bus.mosi;
        else if (miso_mode == 1) bus.miso = 1'b1;
        prev_cs   = bus.cs_n;
        prev_sclk = bus.sclk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           base_rd;
        int           base_act;
        int           sep;
        logic [W-1:0] rw_tx[6];
        logic [W-1:0] rw_sl[6];
        logic [W-1:0] ew[3];

        bus.tx_empty = 1'b1;
        bus.tx_dout  = '0;
        bus.rx_full  = 1'b0;
        bus.miso     = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rst_sclk", bus.sclk, 0);
        check("rst_cs_n", bus.cs_n, 1);
        check("rst_mosi", bus.mosi, 0);
        check("rst_tx_rd_en", bus.tx_rd_en, 0);
        check("rst_rx_wr_en", bus.rx_wr_en, 0);
        check("rst_rx_din", bus.rx_din, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;

        // Empty FIFO with enable high: nothing moves
        enable   = 1'b1;
        base_rd  = rd_cnt;
        base_act = act_cnt;
        repeat (1000) @(negedge clk_sys);
        check("empty_rd_en", rd_cnt - base_rd, 0);
        check("empty_activity", act_cnt - base_act, 0);
        check("empty_cs_n", bus.cs_n, 1);
        check("empty_sclk", bus.sclk, 0);
        check("empty_busy", busy, 0);

        // Single loopback frame
        frames.delete();
        rx_got.delete();
        base_rd = rd_cnt;
        push_tx(16'hA5C3);
        wait_frames(1, 500);
        repeat (4) @(negedge clk_sys);
        check_frame("single", 16'hA5C3, sep);
        check_rx("single", 16'hA5C3);
        check("single_rx_count", rx_got.size(), 0);
        check("single_rd_count", rd_cnt - base_rd, 1);

        // Back-to-back frames
        frames.delete();
        rx_got.delete();
        push_tx(16'h1234);
        push_tx(16'hBEEF);
        wait_frames(2, 1000);
        repeat (4) @(negedge clk_sys);
        check_frame("b2b0", 16'h1234, sep);
        check_frame("b2b1", 16'hBEEF, sep);
        check("b2b_sep", sep >= MIN_SEP, 1);
        check_rx("b2b0", 16'h1234);
        check_rx("b2b1", 16'hBEEF);

        // Randomized words against a scripted slave
        frames.delete();
        rx_got.delete();
        miso_mode = 2;
        for (int i = 0; i < 6; i++) begin
            rw_tx[i] = W'($urandom);
            rw_sl[i] = W'($urandom);
            slave_q.push_back(rw_sl[i]);
            push_tx(rw_tx[i]);
        end
        wait_frames(6, 3000);
        repeat (4) @(negedge clk_sys);
        for (int i = 0; i < 6; i++) begin
            check_frame($sformatf("rnd%0d", i), rw_tx[i], sep);
            if (i > 0) check($sformatf("rnd%0d_sep", i), sep >= MIN_SEP, 1);
            check_rx($sformatf("rnd%0d", i), rw_sl[i]);
        end

        // RX full: word dropped, overflow sticky until cleared
        frames.delete();
        rx_got.delete();
        miso_mode   = 1;
        bus.rx_full = 1'b1;
        push_tx(16'h0F0F);
        wait_frames(1, 500);
        repeat (4) @(negedge clk_sys);
        check_frame("ovf", 16'h0F0F, sep);
        check("ovf_no_push", rx_got.size(), 0);
        check("ovf_set", overflow, 1);
        repeat (20) @(negedge clk_sys);
        check("ovf_sticky", overflow, 1);
        bus.rx_full = 1'b0;
        ovf_clr     = 1'b1;
        @(posedge clk_sys);
        #1;
        check("ovf_cleared", overflow, 0);
        @(negedge clk_sys);
        ovf_clr = 1'b0;

        // Reset during bit 7
        frames.delete();
        rx_got.delete();
        miso_mode = 0;
        push_tx(16'hC3A5);
        wait_bit(8, 500);
        rst_n = 1'b0;
        @(posedge clk_sys);
        #1;
        check("mrst_cs_n", bus.cs_n, 1);
        check("mrst_sclk", bus.sclk, 0);
        check("mrst_busy", busy, 0);
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        check("mrst_no_push", rx_got.size(), 0);
        frames.delete();
        push_tx(16'h5A0F);
        wait_frames(1, 500);
        repeat (4) @(negedge clk_sys);
        check_frame("after_rst", 16'h5A0F, sep);
        check_rx("after_rst", 16'h5A0F);

        // enable dropped mid-frame with more words queued
        frames.delete();
        rx_got.delete();
        base_rd = rd_cnt;
        for (int i = 0; i < 3; i++) begin
            ew[i] = W'($urandom);
            push_tx(ew[i]);
        end
        wait_bit(4, 500);
        enable = 1'b0;
        wait_frames(1, 500);
        repeat (200) @(negedge clk_sys);
        check("endrop_frames", frames.size(), 1);
        check("endrop_rd_count", rd_cnt - base_rd, 1);
        check("endrop_queued", tx_q.size(), 2);
        check("endrop_busy", busy, 0);
        check_frame("endrop0", ew[0], sep);
        check_rx("endrop0", ew[0]);
        enable = 1'b1;
        wait_frames(2, 1000);
        repeat (4) @(negedge clk_sys);
        check_frame("endrop1", ew[1], sep);
        check_frame("endrop2", ew[2], sep);
        check_rx("endrop1", ew[1]);
        check_rx("endrop2", ew[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
